// File: rtl/fpu_short_pkg.sv
// Shared types and constants for the FPU short-op datapaths.
package fpu_short_pkg;

    // Exponent of a value whose leading one sits at bit 31 (127 + 31).
    localparam int unsigned F32_BIAS_W0 = 158;
    localparam int unsigned XLEN        = 32;
    localparam int unsigned LZ_W        = 6;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] man;
    } f32_t;

    // S1: sign and magnitude of the integer operand.
    typedef struct packed {
        logic            sign;
        logic [XLEN-1:0] mag;
    } itof_s1_t;

    // S2: normalised magnitude; the leading one (bit 31) is implicit.
    typedef struct packed {
        logic            sign;
        logic            zero;
        logic [LZ_W-1:0] lz;
        logic [XLEN-2:0] norm;
    } itof_s2_t;

    // S3: packed binary32 result plus inexact flag.
    typedef struct packed {
        f32_t res;
        logic nx;
    } itof_s3_t;

endpackage

// File: rtl/lzc32.sv
// Combinational 32-bit leading-zero counter; returns 32 for an all-zero input.
module lzc32 (
    input  logic [31:0] x,
    output logic [5:0]  cnt
);

    // Scan upward so the highest set bit determines the final count.
    always_comb begin
        cnt = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (x[i]) cnt = 6'(31 - i);
        end
    end

endmodule

// File: rtl/itof_pipe.sv
// Three-stage int32/uint32 to binary32 converter with RNE rounding and tag pass-through.
module itof_pipe
    import fpu_short_pkg::*;
#(
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_x,
    input  logic             in_unsigned,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_res,
    output logic             out_nx,
    output logic [TAG_W-1:0] out_tag
);

    logic             s1_valid, s2_valid, s3_valid;
    itof_s1_t         s1_q, s1_d;
    itof_s2_t         s2_q, s2_d;
    itof_s3_t         s3_q, s3_d;
    logic [TAG_W-1:0] s1_tag, s2_tag, s3_tag;
    logic             s1_adv_c, s2_adv_c, s3_adv_c;
    logic [LZ_W-1:0]  lz_c;

    // A stage advances when empty or when its contents move on this cycle.
    always_comb begin
        s3_adv_c = ~s3_valid | out_ready;
        s2_adv_c = ~s2_valid | s3_adv_c;
        s1_adv_c = ~s1_valid | s2_adv_c;
        in_ready = s1_adv_c;
    end

    // S1 datapath: split the operand into sign and magnitude.
    always_comb begin
        s1_d      = '0;
        s1_d.sign = ~in_unsigned & in_x[31];
        s1_d.mag  = s1_d.sign ? 32'(-in_x) : in_x;
    end

    lzc32 u_lzc (
        .x   (s1_q.mag),
        .cnt (lz_c)
    );

    // S2 datapath: normalise so the leading one lands on bit 31.
    always_comb begin
        s2_d      = '0;
        s2_d.sign = s1_q.sign;
        s2_d.zero = (s1_q.mag == 32'd0);
        s2_d.lz   = lz_c;
        s2_d.norm = 31'(s1_q.mag << lz_c);
    end

    // S3 datapath: round to nearest even and pack.
    always_comb begin
        logic [22:0] man;
        logic        g, st, up;
        logic [23:0] sum;
        logic [7:0]  exp;
        man  = s2_q.norm[30:8];
        g    = s2_q.norm[7];
        st   = |s2_q.norm[6:0];
        up   = g & (st | man[0]);
        sum  = {1'b0, man} + 24'(up);
        exp  = 8'(F32_BIAS_W0 - 32'(s2_q.lz));
        s3_d = '0;
        if (sum[23]) begin
            exp = exp + 8'd1;
        end
        s3_d.res.sign = s2_q.sign;
        s3_d.res.exp  = exp;
        s3_d.res.man  = sum[22:0];
        s3_d.nx       = g | st;
        if (s2_q.zero) begin
            s3_d = '0;
        end
    end

    // S1 register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
            s1_tag   <= '0;
        end else if (s1_adv_c) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_q   <= s1_d;
                s1_tag <= in_tag;
            end
        end
    end

    // S2 register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s2_valid <= 1'b0;
            s2_q     <= '0;
            s2_tag   <= '0;
        end else if (s2_adv_c) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_q   <= s2_d;
                s2_tag <= s1_tag;
            end
        end
    end

    // S3 register; drives the output port directly.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s3_valid <= 1'b0;
            s3_q     <= '0;
            s3_tag   <= '0;
        end else if (s3_adv_c) begin
            s3_valid <= s2_valid;
            if (s2_valid) begin
                s3_q   <= s3_d;
                s3_tag <= s2_tag;
            end
        end
    end

    assign out_valid = s3_valid;
    assign out_res   = s3_q.res;
    assign out_nx    = s3_q.nx;
    assign out_tag   = s3_tag;

endmodule

// File: tb/tb_itof_pipe.sv
// Directed and random checks for the itof_pipe converter.
module tb_itof_pipe;

    localparam int TAG_W = 5;
    localparam int N_RAND = 10000;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_x = '0;
    logic             in_unsigned = 1'b0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_res;
    logic             out_nx;
    logic [TAG_W-1:0] out_tag;

    int checks = 0;
    int failures = 0;

    itof_pipe #(.TAG_W(TAG_W)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_x        (in_x),
        .in_unsigned (in_unsigned),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_res     (out_res),
        .out_nx      (out_nx),
        .out_tag     (out_tag)
    );

    always #5 clk = ~clk;

    // Reference conversion with explicit remainder-vs-half rounding; returns {nx, res}.
    function automatic logic [32:0] ref_cvt(input logic [31:0] x, input logic u);
        logic              s;
        longint unsigned   mag, q, rem, half;
        int                p, sh, e;
        s   = !u && x[31];
        mag = s ? (64'h1_0000_0000 - {32'b0, x}) : {32'b0, x};
        if (mag == 0) return 33'b0;
        p = 0;
        for (int i = 0; i < 32; i++) if (((mag >> i) & 64'd1) != 0) p = i;
        rem = 0;
        if (p <= 23) begin
            q = mag << (23 - p);
        end else begin
            sh   = p - 23;
            q    = mag >> sh;
            rem  = mag & ((64'd1 << sh) - 64'd1);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 64'd1;
        end
        e = 127 + p;
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e = e + 1;
        end
        return {rem != 0, s, 8'(e), q[22:0]};
    endfunction

    task automatic test_reset();
        #2;
        checks++;
        if (out_valid !== 1'b0 || out_res !== 32'h0 || out_nx !== 1'b0 || out_tag !== '0) begin
            failures++;
            $display("FAIL reset_state: got valid=%b res=%h nx=%b tag=%0d, want all 0", out_valid, out_res, out_nx, out_tag);
        end
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: got in_ready=%b want 1", in_ready);
        end
    endtask

    task automatic test_signed_sweep();
        logic [31:0] vx[5] = '{32'h1, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 32'h7FFF_FFFF};
        logic [31:0] vr[5] = '{32'h3F80_0000, 32'hBF80_0000, 32'h0, 32'hCF00_0000, 32'h4F00_0000};
        logic        vn[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = (c < 5);
            if (c < 5) begin
                in_x = vx[c]; in_unsigned = 1'b0; in_tag = 5'(c + 10);
            end
            #1;
            if (c < 5) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL sweep_ready[%0d]: got %b want 1", c, in_ready);
                end
            end
            checks++;
            if (c >= 3 && c < 8) begin
                if (out_valid !== 1'b1 || out_res !== vr[c-3] || out_nx !== vn[c-3] || out_tag !== 5'(c + 7)) begin
                    failures++;
                    $display("FAIL sweep_out[%0d]: got v=%b res=%h nx=%b tag=%0d want v=1 res=%h nx=%b tag=%0d",
                             c - 3, out_valid, out_res, out_nx, out_tag, vr[c-3], vn[c-3], c + 7);
                end
            end else if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL sweep_idle[%0d]: got out_valid=%b want 0", c, out_valid);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_unsigned();
        logic [31:0] vx[2] = '{32'hFFFF_FFFF, 32'h8000_0000};
        logic [31:0] vr[2] = '{32'h4F80_0000, 32'h4F00_0000};
        logic        vn[2] = '{1'b1, 1'b0};
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = (c < 2);
            if (c < 2) begin
                in_x = vx[c]; in_unsigned = 1'b1; in_tag = 5'(c + 3);
            end
            #1;
            checks++;
            if (c >= 3 && c < 5) begin
                if (out_valid !== 1'b1 || out_res !== vr[c-3] || out_nx !== vn[c-3] || out_tag !== 5'(c)) begin
                    failures++;
                    $display("FAIL unsigned_out[%0d]: got v=%b res=%h nx=%b tag=%0d want v=1 res=%h nx=%b tag=%0d",
                             c - 3, out_valid, out_res, out_nx, out_tag, vr[c-3], vn[c-3], c);
                end
            end else if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL unsigned_idle[%0d]: got out_valid=%b want 0", c, out_valid);
            end
        end
        in_valid = 1'b0;
        in_unsigned = 1'b0;
    endtask

    task automatic test_rne_ties();
        logic [31:0] vx[3] = '{32'd16777217, 32'd16777219, 32'd16777218};
        logic [31:0] vr[3] = '{32'h4B80_0000, 32'h4B80_0002, 32'h4B80_0001};
        logic        vn[3] = '{1'b1, 1'b1, 1'b0};
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = (c < 3);
            if (c < 3) begin
                in_x = vx[c]; in_unsigned = 1'b0; in_tag = 5'(c + 20);
            end
            #1;
            checks++;
            if (c >= 3 && c < 6) begin
                if (out_valid !== 1'b1 || out_res !== vr[c-3] || out_nx !== vn[c-3] || out_tag !== 5'(c + 17)) begin
                    failures++;
                    $display("FAIL rne_out[%0d]: got v=%b res=%h nx=%b tag=%0d want v=1 res=%h nx=%b tag=%0d",
                             c - 3, out_valid, out_res, out_nx, out_tag, vr[c-3], vn[c-3], c + 17);
                end
            end else if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL rne_idle[%0d]: got out_valid=%b want 0", c, out_valid);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [31:0] er[5] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h40A0_0000};
        int sent = 0;
        int got = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            out_ready = 1'b0;
            in_valid = (sent < 5); in_x = 32'(sent + 1); in_tag = 5'(sent + 1); in_unsigned = 1'b0;
            #1;
            checks++;
            if (in_ready !== (c < 3)) begin
                failures++;
                $display("FAIL bp_ready[%0d]: got %b want %b", c, in_ready, c < 3);
            end
            if (c >= 3) begin
                checks++;
                if (out_valid !== 1'b1 || out_res !== 32'h3F80_0000 || out_nx !== 1'b0 || out_tag !== 5'd1) begin
                    failures++;
                    $display("FAIL bp_hold[%0d]: got v=%b res=%h nx=%b tag=%0d want v=1 res=3f800000 nx=0 tag=1",
                             c, out_valid, out_res, out_nx, out_tag);
                end
            end
            if (in_valid && in_ready) sent++;
        end
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid = (sent < 5); in_x = 32'(sent + 1); in_tag = 5'(sent + 1);
            #1;
            if (c == 0) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL bp_drain_accept: got in_ready=%b want 1", in_ready);
                end
            end
            if (out_valid) begin
                checks++;
                if (got >= 5) begin
                    failures++;
                    $display("FAIL bp_extra: got extra result res=%h tag=%0d want none", out_res, out_tag);
                end else if (out_res !== er[got] || out_tag !== 5'(got + 1) || out_nx !== 1'b0) begin
                    failures++;
                    $display("FAIL bp_order[%0d]: got res=%h nx=%b tag=%0d want res=%h nx=0 tag=%0d",
                             got, out_res, out_nx, out_tag, er[got], got + 1);
                end
                got++;
            end
            if (in_valid && in_ready) sent++;
        end
        in_valid = 1'b0;
        checks++;
        if (got != 5 || sent != 5) begin
            failures++;
            $display("FAIL bp_count: got results=%0d sent=%0d want 5 and 5", got, sent);
        end
    endtask

    task automatic test_reset_midflight();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            out_ready = 1'b0;
            in_valid = 1'b1; in_x = 32'h7FFF_FFFF; in_unsigned = 1'b0; in_tag = 5'(c + 20);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_tag !== 5'd20 || out_nx !== 1'b1) begin
            failures++;
            $display("FAIL mid_pre: got v=%b tag=%0d nx=%b want v=1 tag=20 nx=1", out_valid, out_tag, out_nx);
        end
        #1 rstn = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_res !== 32'h0 || out_nx !== 1'b0 || out_tag !== '0) begin
            failures++;
            $display("FAIL mid_reset: got v=%b res=%h nx=%b tag=%0d want all 0", out_valid, out_res, out_nx, out_tag);
        end
        #1 rstn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid = 1'b0;
            #1;
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                failures++;
                $display("FAIL mid_stale[%0d]: got out_valid=%b in_ready=%b want 0 and 1", c, out_valid, in_ready);
            end
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid = (c == 0); in_x = 32'hFFFF_FFFE; in_unsigned = 1'b0; in_tag = 5'd9;
            #1;
            checks++;
            if (c == 3) begin
                if (out_valid !== 1'b1 || out_res !== 32'hC000_0000 || out_nx !== 1'b0 || out_tag !== 5'd9) begin
                    failures++;
                    $display("FAIL mid_new: got v=%b res=%h nx=%b tag=%0d want v=1 res=c0000000 nx=0 tag=9",
                             out_valid, out_res, out_nx, out_tag);
                end
            end else if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL mid_new_idle[%0d]: got out_valid=%b want 0", c, out_valid);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_random();
        logic [32:0]      q_res[$];
        logic [TAG_W-1:0] q_tag[$];
        logic [32:0]      exp_r;
        logic [TAG_W-1:0] exp_t;
        int  sent = 0;
        int  cyc = 0;
        logic pending = 1'b0;
        while ((sent < N_RAND || q_res.size() > 0) && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            if (!pending && sent < N_RAND && $urandom_range(0, 3) != 0) begin
                case ($urandom_range(0, 3))
                    0: in_x = $urandom();
                    1: in_x = 32'($urandom_range(0, 300)) - 32'd150;
                    2: in_x = 32'h0100_0000 | 32'($urandom_range(0, 16));
                    default: in_x = (32'h1 << $urandom_range(0, 31)) + 32'($urandom_range(0, 2)) - 32'd1;
                endcase
                in_unsigned = 1'($urandom_range(0, 1));
                in_tag = 5'(sent);
                pending = 1'b1;
            end
            in_valid  = pending;
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid && out_ready) begin
                checks++;
                if (q_res.size() == 0) begin
                    failures++;
                    $display("FAIL rand_spurious: got res=%h tag=%0d want no result", out_res, out_tag);
                end else begin
                    exp_r = q_res.pop_front();
                    exp_t = q_tag.pop_front();
                    if (out_res !== exp_r[31:0] || out_nx !== exp_r[32] || out_tag !== exp_t) begin
                        failures++;
                        $display("FAIL rand_out: got res=%h nx=%b tag=%0d want res=%h nx=%b tag=%0d",
                                 out_res, out_nx, out_tag, exp_r[31:0], exp_r[32], exp_t);
                    end
                end
            end
            if (in_valid && in_ready) begin
                q_res.push_back(ref_cvt(in_x, in_unsigned));
                q_tag.push_back(in_tag);
                pending = 1'b0;
                sent++;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (sent != N_RAND || q_res.size() != 0) begin
            failures++;
            $display("FAIL rand_timeout: got sent=%0d outstanding=%0d want %0d and 0", sent, q_res.size(), N_RAND);
        end
    endtask

    initial begin
        test_reset();
        test_signed_sweep();
        test_unsigned();
        test_rne_ties();
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
